// File: rtl/quality_grader.sv
// Pass/fail criteria grader: popcount score -> LOW/MEDIUM/HIGH LED held HOLD_CYCLES cycles.
// Define QG_STATS_EN to build the per-grade saturating statistics counters.
module quality_grader #(
    parameter int unsigned N_CRIT      = 3,
    parameter int unsigned MED_MIN     = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CRIT-1:0] crit_ok_i,
    input  logic              sample_i,
    input  logic              clear_i,
    output logic              led_low_o,
    output logic              led_medium_o,
    output logic              led_high_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  cnt_low_o,
    output logic [CNT_W-1:0]  cnt_medium_o,
    output logic [CNT_W-1:0]  cnt_high_o
);

    typedef enum logic [1:0] {StIdle, StScore, StShow} state_e;

    state_e            state_q, state_d;
    logic [N_CRIT-1:0] flags_q, flags_d;
    logic [7:0]        hold_q, hold_d;
    logic [2:0]        led_q, led_d;   // {high, medium, low}
    logic              busy_q, busy_d;
    logic [3:0]        score;
    logic [2:0]        grade;

    always_comb begin
        score = '0;
        for (int i = 0; i < int'(N_CRIT); i++) begin
            score = score + 4'(flags_q[i]);
        end
        if (score == 4'(N_CRIT)) begin
            grade = 3'b100;
        end else if (score >= 4'(MED_MIN)) begin
            grade = 3'b010;
        end else begin
            grade = 3'b001;
        end
    end

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        hold_d  = hold_q;
        led_d   = led_q;
        case (state_q)
            StIdle: begin
                if (sample_i) begin
                    flags_d = crit_ok_i;
                    state_d = StScore;
                end
            end
            StScore: begin
                led_d   = grade;
                hold_d  = 8'(HOLD_CYCLES);
                state_d = StShow;
            end
            StShow: begin
                if (hold_q == 8'd1) begin
                    led_d   = '0;
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                led_d   = '0;
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            flags_q <= '0;
            hold_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            hold_q  <= hold_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign led_high_o   = led_q[2];
    assign led_medium_o = led_q[1];
    assign led_low_o    = led_q[0];
    assign busy_o       = busy_q;

`ifdef QG_STATS_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_low_q, cnt_medium_q, cnt_high_q;

    // Clear wins over the SCORE->SHOW increment; counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_low_q    <= '0;
            cnt_medium_q <= '0;
            cnt_high_q   <= '0;
        end else if (clear_i) begin
            cnt_low_q    <= '0;
            cnt_medium_q <= '0;
            cnt_high_q   <= '0;
        end else if (state_q == StScore) begin
            unique case (grade)
                3'b001:  if (cnt_low_q != CntMax) cnt_low_q <= cnt_low_q + 1'b1;
                3'b010:  if (cnt_medium_q != CntMax) cnt_medium_q <= cnt_medium_q + 1'b1;
                3'b100:  if (cnt_high_q != CntMax) cnt_high_q <= cnt_high_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign cnt_low_o    = cnt_low_q;
    assign cnt_medium_o = cnt_medium_q;
    assign cnt_high_o   = cnt_high_q;
`else
    logic unused_clear;
    assign unused_clear = clear_i;
    assign cnt_low_o    = '0;
    assign cnt_medium_o = '0;
    assign cnt_high_o   = '0;
`endif

endmodule
